// File: rtl/flappy_game_ctrl.sv
// Flappy Bird game sequencer: step-rate divider, bird physics, collision and scoring
// against the pipe scroller's green array, and the red bird overlay.
module flappy_game_ctrl #(
   parameter int unsigned TICK_DIV  = 8,
   parameter int unsigned START_ROW = 7,
   parameter int unsigned BIRD_COL  = 4
) (
   input  logic              clk,
   input  logic              RST,
   input  logic              flap,
   input  logic [15:0][15:0] GrnPixels,
   output logic              pipe_rst,
   output logic              pipe_step,
   output logic [15:0][15:0] RedPixels,
   output logic [3:0]        bird_row,
   output logic [7:0]        score,
   output logic              playing,
   output logic              game_over
);

   // state   | meaning
   // S_IDLE  | waiting for a start press, pipe scroller held in reset
   // S_PLAY  | counting cycles towards the next game step
   // S_STEP  | one cycle: pipes shift, bird moves or hits the ground
   // S_CHECK | one cycle: collision and scoring against the shifted pipes
   // S_OVER  | pipe image frozen until a press returns to idle
   typedef enum logic [2:0] {S_IDLE, S_PLAY, S_STEP, S_CHECK, S_OVER} state_t;

   localparam logic [3:0]  START_ROW_L = 4'(START_ROW);
   localparam logic [3:0]  BIRD_COL_L  = 4'(BIRD_COL);
   localparam logic [15:0] TICK_LAST   = 16'(TICK_DIV - 1);

   state_t            state_q, state_d;
   logic [15:0]       tick_q, tick_d;
   logic              flap_dly_q, flap_dly_d;
   logic              flap_req_q, flap_req_d;
   logic [3:0]        bird_row_q, bird_row_d;
   logic [7:0]        score_q, score_d;
   logic              pipe_rst_q, pipe_rst_d;
   logic              pipe_step_q, pipe_step_d;
   logic              playing_q, playing_d;
   logic              game_over_q, game_over_d;
   logic [15:0][15:0] red_q, red_d;

   logic              flap_rise;
   logic [15:0]       grn_col;

   function automatic logic [15:0][15:0] bird_mask(input logic [3:0] row);
      logic [15:0][15:0] m;
      m = '0;
      m[row][BIRD_COL_L] = 1'b1;
      return m;
   endfunction

   always_comb begin
      for (int r = 0; r < 16; r++) begin
         grn_col[r] = GrnPixels[r][BIRD_COL_L];
      end
   end

   always_comb begin
      state_d    = state_q;
      tick_d     = tick_q;
      flap_dly_d = flap;
      flap_req_d = flap_req_q;
      bird_row_d = bird_row_q;
      score_d    = score_q;
      flap_rise  = flap & ~flap_dly_q;

      case (state_q)
         S_IDLE: begin
            tick_d = '0;
            if (flap_rise) begin
               state_d    = S_PLAY;
               score_d    = '0;
               flap_req_d = 1'b0;
            end
         end
         S_PLAY: begin
            if (flap_rise) flap_req_d = 1'b1;
            if (tick_q == TICK_LAST) begin
               tick_d  = '0;
               state_d = S_STEP;
            end else begin
               tick_d = tick_q + 16'd1;
            end
         end
         S_STEP: begin
            tick_d     = tick_q + 16'd1;
            flap_req_d = flap_rise;
            if (flap_req_q) begin
               bird_row_d = (bird_row_q == 4'd0) ? 4'd0 : bird_row_q - 4'd1;
               state_d    = S_CHECK;
            end else if (bird_row_q == 4'd15) begin
               state_d = S_OVER;
            end else begin
               bird_row_d = bird_row_q + 4'd1;
               state_d    = S_CHECK;
            end
         end
         S_CHECK: begin
            if (flap_rise) flap_req_d = 1'b1;
            if (grn_col[bird_row_q]) begin
               state_d = S_OVER;
            end else begin
               if ((|grn_col) && (score_q != 8'hFF)) score_d = score_q + 8'd1;
               // CHECK is part of the step period, so TICK_DIV=2 goes straight back to STEP
               if (tick_q == TICK_LAST) begin
                  tick_d  = '0;
                  state_d = S_STEP;
               end else begin
                  tick_d  = tick_q + 16'd1;
                  state_d = S_PLAY;
               end
            end
         end
         S_OVER: begin
            tick_d = '0;
            if (flap_rise) begin
               state_d    = S_IDLE;
               bird_row_d = START_ROW_L;
               flap_req_d = 1'b0;
            end
         end
         default: begin
            state_d = S_IDLE;
            tick_d  = '0;
         end
      endcase

      // A ground hit in STEP issues no shift, so the pipe image freezes as it was
      pipe_step_d = (state_d == S_STEP) && (flap_req_d || (bird_row_d != 4'd15));
      pipe_rst_d  = (state_d == S_IDLE);
      playing_d   = (state_d == S_PLAY) || (state_d == S_STEP) || (state_d == S_CHECK);
      game_over_d = (state_d == S_OVER);
      red_d       = bird_mask(bird_row_d);
   end

   always_ff @(posedge clk) begin
      if (RST) begin
         state_q     <= S_IDLE;
         tick_q      <= '0;
         flap_dly_q  <= 1'b0;
         flap_req_q  <= 1'b0;
         bird_row_q  <= START_ROW_L;
         score_q     <= '0;
         pipe_rst_q  <= 1'b1;
         pipe_step_q <= 1'b0;
         playing_q   <= 1'b0;
         game_over_q <= 1'b0;
         red_q       <= bird_mask(START_ROW_L);
      end else begin
         state_q     <= state_d;
         tick_q      <= tick_d;
         flap_dly_q  <= flap_dly_d;
         flap_req_q  <= flap_req_d;
         bird_row_q  <= bird_row_d;
         score_q     <= score_d;
         pipe_rst_q  <= pipe_rst_d;
         pipe_step_q <= pipe_step_d;
         playing_q   <= playing_d;
         game_over_q <= game_over_d;
         red_q       <= red_d;
      end
   end

   assign pipe_rst  = pipe_rst_q;
   assign pipe_step = pipe_step_q;
   assign RedPixels = red_q;
   assign bird_row  = bird_row_q;
   assign score     = score_q;
   assign playing   = playing_q;
   assign game_over = game_over_q;

endmodule
